perf_event_monitor: RTL and testbench

//   Synthesizable performance monitor for the WISC pipeline. Counts cycles and NUM_EVENTS
//   per-cycle event strobes, e.g. retire, DCacheHit, ICacheHit, DCacheReq and ICacheReq.

---
 rtl/perf_pkg.sv | 22 ++
 rtl/perf_event_counter.sv | 60 ++++++
 rtl/perf_event_monitor.sv | 121 ++++++++++++
 tb/tb_perf_event_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_pkg : FSM state encoding and event channel indices for the monitor. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } perf_state_e;

  localparam int EV_RETIRE = 0;
  localparam int EV_DHIT   = 1;
  localparam int EV_IHIT   = 2;
  localparam int EV_DREQ   = 3;
  localparam int EV_IREQ   = 4;

endpackage
`default_nettype wire

// File: rtl/perf_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_event_counter : one CNT_W counter with sticky overflow flag.        |
// | Overflow mode: PERF_SATURATE_EN defined -> saturate, else wrap.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             w_at_max;

  assign w_at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (w_at_max) begin
        ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/perf_event_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_event_monitor : cycle/event counters frozen on halt, then dumped    |
// | over valid/ready. Overflow mode selected by PERF_SATURATE_EN.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 5,
  parameter int CNT_W      = 32,
  parameter int IDX_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  halt_i,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [IDX_W-1:0]      dump_idx,
  output logic [CNT_W-1:0]      dump_data,
  output logic                  dump_last,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic                  busy,
  output logic                  done
);

  localparam int c_NCNT = NUM_EVENTS + 1;

  perf_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CNT_W-1:0] w_cnt [c_NCNT];
  logic [c_NCNT-1:0] w_inc;
  logic [c_NCNT-1:0] w_ovf;
  logic             w_clr;
  logic             w_count_en;
  logic             w_last;

  // A clear in COUNT drops that cycle's increments entirely.
  assign w_clr      = clear && (state_q == COUNT || state_q == DONE);
  assign w_count_en = (state_q == COUNT) && !clear;
  assign w_last     = (idx_q == IDX_W'(NUM_EVENTS));

  assign w_inc[0] = w_count_en;

  perf_event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_inc[0]),
    .cnt   (w_cnt[0]),
    .ovf   (w_ovf[0])
  );

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_evt
    assign w_inc[i+1] = w_count_en && event_i[i];

    perf_event_counter #(.CNT_W(CNT_W)) u_evt_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .inc   (w_inc[i+1]),
      .cnt   (w_cnt[i+1]),
      .ovf   (w_ovf[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (enable) state_d = COUNT;
      COUNT: if (halt_i) state_d = DRAIN;
      DRAIN: begin
        if (dump_ready) begin
          if (w_last) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:  if (clear) state_d = IDLE;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Counters are frozen outside COUNT, so the mux output is stable while stalled.
  always_comb begin
    dump_data = '0;
    for (int k = 0; k < c_NCNT; k++) begin
      if (dump_valid && idx_q == IDX_W'(k)) dump_data = w_cnt[k];
    end
  end

  assign dump_valid = (state_q == DRAIN);
  assign dump_idx   = idx_q;
  assign dump_last  = dump_valid && w_last;
  assign ovf_o      = w_ovf;
  assign busy       = (state_q == COUNT) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_perf_event_monitor : randomized scoreboard bench for the monitor.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_perf_event_monitor;
  import perf_pkg::*;

  localparam int NE = 5;
  localparam int CW = 4;
  localparam int IW = $clog2(NE + 1);
  localparam int unsigned MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clear;
  logic [NE-1:0] event_i;
  logic          halt_i;
  logic          dump_ready;
  logic          dump_valid;
  logic [IW-1:0] dump_idx;
  logic [CW-1:0] dump_data;
  logic          dump_last;
  logic [NE:0]   ovf_o;
  logic          busy;
  logic          done;

  perf_event_monitor #(.NUM_EVENTS(NE), .CNT_W(CW), .IDX_W(IW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .event_i    (event_i),
    .halt_i     (halt_i),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .ovf_o      (ovf_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [CW-1:0] data;
    bit          last;
    logic [NE:0] ovf;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned tc[NE+1];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: true event totals since last clear, folded to CNT_W at dump time.
  function automatic logic [CW-1:0] model_val(int unsigned n);
`ifdef PERF_SATURATE_EN
    return (n > MAXV) ? CW'(MAXV) : CW'(n);
`else
    return CW'(n % (MAXV + 1));
`endif
  endfunction

  function automatic void model_zero();
    for (int k = 0; k <= NE; k++) tc[k] = 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dump_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
      end else begin
        check("dump_idx", 32'(dump_idx), 32'(sb_q[0].idx));
        check("dump_data", 32'(dump_data), 32'(sb_q[0].data));
        check("dump_last", 32'(dump_last), 32'(sb_q[0].last));
        check("ovf_o", 32'(ovf_o), 32'(sb_q[0].ovf));
        if (dump_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic run_session(input int n, input bit rnd_ev, input logic [NE-1:0] fix_ev,
                             input int clr_at, input int rmode, input int abort_after);
    logic [NE-1:0] ev;
    logic [NE:0]   eo;
    int            xfers;
    bit            aborted;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int c = 1; c <= n; c++) begin
      ev      = rnd_ev ? NE'($urandom) : fix_ev;
      event_i = ev;
      clear   = (c == clr_at);
      halt_i  = (c == n);
      if (c == clr_at) model_zero();
      else begin
        tc[0]++;
        for (int i = 0; i < NE; i++) if (ev[i]) tc[i+1]++;
      end
      @(posedge clk); #1;
      if (c < n) begin
        check("busy_count", 32'(busy), 32'd1);
        check("done_count", 32'(done), 32'd0);
      end
    end
    event_i = '0;
    clear   = 1'b0;
    halt_i  = 1'b0;
    for (int k = 0; k <= NE; k++) eo[k] = (tc[k] > MAXV);
    for (int k = 0; k <= NE; k++) sb_q.push_back('{k, model_val(tc[k]), (k == NE), eo});
    check("busy_drain", 32'(busy), 32'd1);

    xfers   = 0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (abort_after >= 0 && xfers == abort_after) begin
        dump_ready = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        model_zero();
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idx", 32'(dump_idx), 32'd0);
        check("abort_ovf", 32'(ovf_o), 32'd0);
        aborted = 1'b1;
        break;
      end
      case (rmode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc >= 4) && ((cyc - 4) % 2 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (dump_ready && dump_valid) xfers++;
      @(posedge clk); #1;
      if (done) break;
    end
    dump_ready = 1'b0;
    if (!aborted) begin
      check("done_flag", 32'(done), 32'd1);
      check("transfer_count", 32'(xfers), 32'(NE + 1));
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_zero();
      check("done_after_clear", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int ca;
    rst_n      = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    event_i    = '0;
    halt_i     = 1'b0;
    dump_ready = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_idx", 32'(dump_idx), 32'd0);
    check("rst_data", 32'(dump_data), 32'd0);
    check("rst_last", 32'(dump_last), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Idle cycles must not count, even with events asserted.
    event_i = '1;
    repeat (3) @(posedge clk);
    #1;
    event_i = '0;

    run_session(10, 1'b0, 5'b00011, -1, 0, -1);
    run_session(6, 1'b1, '0, -1, 1, -1);
    run_session(20, 1'b0, 5'b00001, -1, 0, -1);
    run_session(8, 1'b1, '0, 8, 2, -1);
    run_session(12, 1'b1, '0, -1, 0, 2);
    run_session(5, 1'b1, '0, -1, 0, -1);
    run_session(3, 1'b0, (NE'(1) << EV_IREQ) | (NE'(1) << EV_RETIRE), -1, 2, -1);
    for (int r = 0; r < 10; r++) begin
      n  = int'($urandom_range(1, 40));
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1;
      run_session(n, 1'b1, '0, ca, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
